// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer. It issues one instruction-memory request at a time
// and queues the returned words, each tagged with its fetch address, for decode.
// A redirect flushes the queue. It also discards any request still in flight.
// Optional feature: define IFB_BYPASS_EN to hand a returning word straight to
// decode in its ack cycle when the queue is empty.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no request outstanding; may accept a new pc_addr
// WAIT_ACK | request outstanding; returned word will be queued
// DRAIN    | request outstanding but flushed by redirect; word discarded
module instr_fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pc_addr,
  input  logic                     pc_valid,
  output logic                     pc_ready,
  input  logic                     redirect,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              instr,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic fifo_empty;
  logic fifo_full;
  logic xfer;
  logic ack_live;
  logic bypass_take;
  logic push;
  logic pop;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_COUNT);

  // Reset gating keeps pc_ready low during reset even though the FSM idles there.
  assign pc_ready = reset && (state == IDLE) && !fifo_full && !redirect;
  assign xfer     = pc_valid && pc_ready;

  // A word returning for a live (not flushed) request.
  assign ack_live = (state == WAIT_ACK) && imem_ack && !redirect;

`ifdef IFB_BYPASS_EN
  // Empty queue: present the returning word directly; if taken, do not queue it.
  assign bypass_take = ack_live && fifo_empty && instr_ready;
  assign instr_valid = !fifo_empty || ack_live;
  assign instr       = fifo_empty ? imem_rdata : mem_instr[rd_ptr];
  assign instr_pc    = fifo_empty ? imem_addr  : mem_pc[rd_ptr];
`else
  // Head of queue only; data from memory reaches decode one cycle after ack.
  assign bypass_take = 1'b0;
  assign instr_valid = !fifo_empty;
  assign instr       = mem_instr[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];
`endif

  assign push = ack_live && !fifo_full && !bypass_take;
  assign pop  = !fifo_empty && instr_ready;

  // Request FSM: one outstanding request, address held until ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            imem_addr <= pc_addr;
            imem_req  <= 1'b1;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end else if (redirect) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; redirect wins over push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Queue storage; cleared on reset so the head reads zero before the first push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (push) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]    <= imem_addr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer. A queue-based model tracks the expected
// contents and request status, and every negedge compares the DUT against it.
// Directed sequences add literal checks at their key points.
module tb_instr_fetch_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
`ifdef IFB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] pc_addr = '0;
  logic              pc_valid = 1'b0;
  logic              pc_ready;
  logic              redirect = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;

  int vec_cnt  = 0;
  int fail_cnt = 0;

  instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .redirect(redirect), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [ADDR_W-1:0] qpc[$];
  logic [31:0]       qin[$];
  bit                m_out   = 1'b0;
  bit                m_drain = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  int                m_sz;
  bit                m_ret;

  always @(negedge reset) begin
    qpc.delete();
    qin.delete();
    m_out   = 1'b0;
    m_drain = 1'b0;
    m_addr  = '0;
  end

  // Advance the model on each active edge from the inputs seen there.
  always @(posedge clk) begin
    if (reset) begin
      m_sz  = qpc.size();
      m_ret = m_out && !m_drain && imem_ack;
      if (redirect) begin
        qpc.delete();
        qin.delete();
      end else begin
        if (m_sz > 0 && instr_ready) begin
          void'(qpc.pop_front());
          void'(qin.pop_front());
        end
        if (m_ret && !(BYP && m_sz == 0 && instr_ready)) begin
          qpc.push_back(m_addr);
          qin.push_back(imem_rdata);
        end
      end
      if (m_out) begin
        if (imem_ack) begin
          m_out   = 1'b0;
          m_drain = 1'b0;
        end else if (redirect) begin
          m_drain = 1'b1;
        end
      end else if (pc_valid && !redirect && m_sz < DEPTH) begin
        m_out  = 1'b1;
        m_addr = pc_addr;
      end
    end
  end

  // Compare DUT against model on every falling edge.
  bit e_byp;
  bit e_valid;
  always @(negedge clk) begin
    e_byp   = BYP && reset && qpc.size() == 0 && m_out && !m_drain && imem_ack && !redirect;
    e_valid = (qpc.size() != 0) || e_byp;
    chk("fifo_count", 32'(fifo_count), 32'(qpc.size()));
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    chk("imem_req", 32'(imem_req), 32'(m_out));
    chk("imem_addr", 32'(imem_addr), 32'(m_addr));
    chk("pc_ready", 32'(pc_ready),
        32'(reset && !m_out && qpc.size() < DEPTH && !redirect));
    if (qpc.size() != 0) begin
      chk("instr", instr, qin[0]);
      chk("instr_pc", 32'(instr_pc), 32'(qpc[0]));
    end else if (e_byp) begin
      chk("instr_byp", instr, imem_rdata);
      chk("instr_pc_byp", 32'(instr_pc), 32'(m_addr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input int dly, input bit pop_on_ack);
    int guard = 0;
    while (!pc_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) chk("pc_ready_timeout", 32'(pc_ready), 32'd1);
    pc_valid = 1'b1;
    pc_addr  = a;
    step();
    pc_valid = 1'b0;
    repeat (dly) step();
    imem_ack    = 1'b1;
    imem_rdata  = d;
    instr_ready = pop_on_ack;
    step();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", 32'(instr_pc), 32'h0);
    chk("rst_pc_ready", 32'(pc_ready), 32'h0);
    reset = 1'b1;
    step();

    // first fetch, ack two cycles after request
    fetch(10'd0, 32'h0000_0013, 2, 1'b0);
    chk("t1_instr", instr, 32'h0000_0013);
    chk("t1_instr_pc", 32'(instr_pc), 32'h0);
    chk("t1_count", 32'(fifo_count), 32'd1);
    chk("t1_imem_addr", 32'(imem_addr), 32'h0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;

    // fill to full, then pop one
    for (int a = 1; a <= 4; a++) fetch(ADDR_W'(a), 32'h100 + 32'(a), 1, 1'b0);
    chk("t2_full_count", 32'(fifo_count), 32'd4);
    chk("t2_full_pc_ready", 32'(pc_ready), 32'd0);
    chk("t2_head_pc", 32'(instr_pc), 32'd1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t2_count3", 32'(fifo_count), 32'd3);
    chk("t2_next_pc", 32'(instr_pc), 32'd2);
    chk("t2_pc_ready", 32'(pc_ready), 32'd1);
    instr_ready = 1'b1;
    repeat (3) step();
    instr_ready = 1'b0;
    chk("t2_drained", 32'(fifo_count), 32'd0);

    // redirect while waiting -> drain, data discarded
    pc_valid = 1'b1;
    pc_addr  = 10'd6;
    step();
    pc_valid = 1'b0;
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    chk("t3_drain_pc_ready", 32'(pc_ready), 32'd0);
    chk("t3_drain_req", 32'(imem_req), 32'd1);
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("t3_req_low", 32'(imem_req), 32'd0);
    chk("t3_count", 32'(fifo_count), 32'd0);
    chk("t3_valid", 32'(instr_valid), 32'd0);
    chk("t3_pc_ready", 32'(pc_ready), 32'd1);

    // redirect together with ack -> discard, back to idle
    pc_valid = 1'b1;
    pc_addr  = 10'd7;
    step();
    pc_valid   = 1'b0;
    imem_ack   = 1'b1;
    redirect   = 1'b1;
    imem_rdata = 32'h7777_7777;
    step();
    imem_ack = 1'b0;
    redirect = 1'b0;
    chk("t4_count", 32'(fifo_count), 32'd0);
    chk("t4_req", 32'(imem_req), 32'd0);

    // redirect overrides simultaneous push and pop
    fetch(10'd8, 32'h888, 0, 1'b0);
    fetch(10'd9, 32'h999, 0, 1'b0);
    pc_valid = 1'b1;
    pc_addr  = 10'd10;
    step();
    pc_valid    = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'hAAA;
    instr_ready = 1'b1;
    redirect    = 1'b1;
    step();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    chk("t5_flush_count", 32'(fifo_count), 32'd0);

    // stray ack in idle is ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555;
    step();
    imem_ack = 1'b0;
    chk("t6_idle_ack", 32'(fifo_count), 32'd0);

    // steady stream: push and pop together, pointers wrap
    fetch(10'd0, 32'h2000, 0, 1'b0);
    fetch(10'd1, 32'h2001, 0, 1'b0);
    for (int a = 2; a <= 9; a++) begin
      fetch(ADDR_W'(a), 32'h2000 + 32'(a), 0, 1'b1);
      chk("t7_const_count", 32'(fifo_count), 32'd2);
    end
    chk("t7_head_pc", 32'(instr_pc), 32'd8);
    chk("t7_head_instr", instr, 32'h2008);

    // reset mid-request
    pc_valid = 1'b1;
    pc_addr  = 10'h55;
    step();
    pc_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("t8_req", 32'(imem_req), 32'd0);
    chk("t8_count", 32'(fifo_count), 32'd0);
    chk("t8_instr", instr, 32'd0);
    chk("t8_instr_pc", 32'(instr_pc), 32'd0);
    #1;
    reset = 1'b1;
    step();
    fetch(10'h20, 32'h0ABC, 1, 1'b0);
    chk("t8_refetch_pc", 32'(instr_pc), 32'h20);
    chk("t8_refetch_instr", instr, 32'h0ABC);
    chk("t8_refetch_count", 32'(fifo_count), 32'd1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;

`ifdef IFB_BYPASS_EN
    // bypass: empty queue, decode ready in ack cycle
    pc_valid = 1'b1;
    pc_addr  = 10'h30;
    step();
    pc_valid    = 1'b0;
    instr_ready = 1'b1;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h00A0_0093;
    #1;
    chk("t9_byp_valid", 32'(instr_valid), 32'd1);
    chk("t9_byp_instr", instr, 32'h00A0_0093);
    chk("t9_byp_pc", 32'(instr_pc), 32'h30);
    step();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    chk("t9_byp_count", 32'(fifo_count), 32'd0);
`endif

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
